player_unit: RTL

//  Executes the 16-bit player instruction stream from the game state machine during DODGE.

---
 rtl/player_pkg.sv | 46 ++++
 rtl/frame_timer.sv | 31 +++
 rtl/player_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/player_pkg.sv
// Shared definitions for the player unit: opcodes, directions, instruction fields, FSM states
// and the one-axis step-and-clamp helper used for movement.
package player_pkg;

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_MOV = 4'b0101;
   localparam logic [3:0] OP_SHP = 4'b0110;

   localparam logic [3:0] DIR_UP    = 4'd0;
   localparam logic [3:0] DIR_RIGHT = 4'd1;
   localparam logic [3:0] DIR_DOWN  = 4'd2;
   localparam logic [3:0] DIR_LEFT  = 4'd3;

   typedef enum logic [1:0] {
      ALIVE  = 2'd0,
      INVULN = 2'd1,
      DEAD   = 2'd2
   } state_t;

   function automatic logic [3:0] instr_op(input logic [15:0] instr);
      return instr[15:12];
   endfunction

   function automatic logic [3:0] instr_dir(input logic [15:0] instr);
      return instr[11:8];
   endfunction

   function automatic logic [7:0] instr_operand(input logic [15:0] instr);
      return instr[7:0];
   endfunction

   // Widening to 11 bits keeps pos-step and pos+step from wrapping before the clamp.
   function automatic logic [9:0] step_clamp(input logic [9:0]  pos,
                                             input logic        inc,
                                             input logic [10:0] step,
                                             input logic [10:0] lo,
                                             input logic [10:0] hi);
      logic [10:0] p;
      logic [10:0] r;
      p = {1'b0, pos};
      if (inc) r = (p + step > hi) ? hi : p + step;
      else     r = (p < lo + step) ? lo : p - step;
      return 10'(r);
   endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable down-counter advanced by frame_tick; done marks the tick that takes it from 1 to 0,
// idle is high while the count sits at zero.
module frame_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             tick,
   output logic             done,
   output logic             idle
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load)                          count_d = load_val;
      else if (tick && count_q != '0)    count_d = count_q - WIDTH'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign done = tick && (count_q == WIDTH'(1));
   assign idle = (count_q == '0);

endmodule

// File: rtl/player_unit.sv
// Player instruction executor for DODGE: movement, HP/hit handling and the ALIVE/INVULN/DEAD FSM.
// Define HP_REGEN_EN to add slow HP regeneration while ALIVE.
module player_unit
   import player_pkg::*;
#(
   parameter int ARENA_X0    = 200,
   parameter int ARENA_X1    = 440,
   parameter int ARENA_Y0    = 240,
   parameter int ARENA_Y1    = 400,
   parameter int PLAYER_SIZE = 16,
   parameter int STEP        = 4,
   parameter int MAX_HP      = 20,
   parameter int HIT_DMG     = 3,
   parameter int INV_FRAMES  = 30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instr,
   input  logic        frame_tick,
   input  logic        hit,
   output logic [9:0]  player_x,
   output logic [9:0]  player_y,
   output logic [7:0]  hp,
   output logic        is_move,
   output logic        invuln,
   output logic        is_death
);

   localparam logic [10:0] X_MIN = 11'(ARENA_X0);
   localparam logic [10:0] X_MAX = 11'(ARENA_X1 - PLAYER_SIZE);
   localparam logic [10:0] Y_MIN = 11'(ARENA_Y0);
   localparam logic [10:0] Y_MAX = 11'(ARENA_Y1 - PLAYER_SIZE);
   localparam logic [10:0] STP   = 11'(STEP);
   localparam logic [9:0]  X_RST = 10'((ARENA_X0 + ARENA_X1 - PLAYER_SIZE) / 2);
   localparam logic [9:0]  Y_RST = 10'((ARENA_Y0 + ARENA_Y1 - PLAYER_SIZE) / 2);
   localparam logic [7:0]  HP_MAX = 8'(MAX_HP);
   localparam logic [7:0]  DMG    = 8'(HIT_DMG);

   state_t      state_q, state_d;
   logic [9:0]  x_q, x_d, y_q, y_d, nx, ny;
   logic [7:0]  hp_q, hp_d, hp_cap, hp_hit;
   logic        move_q, move_d, invuln_q, invuln_d, death_q, death_d;
   logic        shp_acc, mov_acc, inv_load, inv_done, inv_idle;
   logic [3:0]  op, dir;
   logic [7:0]  operand;

   assign op      = instr_op(instr);
   assign dir     = instr_dir(instr);
   assign operand = instr_operand(instr);
   assign shp_acc = (op == OP_SHP);
   assign mov_acc = (op == OP_MOV) && frame_tick && (state_q != DEAD) && (dir <= DIR_LEFT);
   assign hp_cap  = (operand > HP_MAX) ? HP_MAX : operand;
   assign hp_hit  = (hp_q > DMG) ? hp_q - DMG : 8'd0;

   frame_timer #(.WIDTH(8)) u_inv_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (inv_load),
      .load_val (8'(INV_FRAMES)),
      .tick     (frame_tick),
      .done     (inv_done),
      .idle     (inv_idle)
   );

`ifdef HP_REGEN_EN
   logic regen_load, regen_done, regen_idle;
   // The regen window restarts whenever HP is touched from outside or the player leaves ALIVE.
   assign regen_load = (state_q != ALIVE) || hit || shp_acc || regen_done || regen_idle;

   frame_timer #(.WIDTH(8)) u_regen_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (regen_load),
      .load_val (8'd120),
      .tick     (frame_tick),
      .done     (regen_done),
      .idle     (regen_idle)
   );
`endif

   always_comb begin
      nx = x_q;
      ny = y_q;
      case (dir)
         DIR_UP:    ny = step_clamp(y_q, 1'b0, STP, Y_MIN, Y_MAX);
         DIR_DOWN:  ny = step_clamp(y_q, 1'b1, STP, Y_MIN, Y_MAX);
         DIR_LEFT:  nx = step_clamp(x_q, 1'b0, STP, X_MIN, X_MAX);
         DIR_RIGHT: nx = step_clamp(x_q, 1'b1, STP, X_MIN, X_MAX);
         default:   ;
      endcase
   end

   // NOTE: every always_comb target gets a default first so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      hp_d     = hp_q;
      move_d   = 1'b0;
      inv_load = 1'b0;

      if (mov_acc) begin
         x_d    = nx;
         y_d    = ny;
         move_d = (nx != x_q) || (ny != y_q);
      end

      if (shp_acc) begin
         hp_d    = hp_cap;
         state_d = (hp_cap == 8'd0) ? DEAD : ALIVE;
      end else begin
         case (state_q)
            ALIVE: begin
               if (hit) begin
                  hp_d = hp_hit;
                  if (hp_hit == 8'd0) begin
                     state_d = DEAD;
                  end else begin
                     state_d  = INVULN;
                     inv_load = 1'b1;
                  end
               end
`ifdef HP_REGEN_EN
               else if (regen_done && hp_q < HP_MAX) begin
                  hp_d = hp_q + 8'd1;
               end
`endif
            end
            INVULN:  if (inv_done || inv_idle) state_d = ALIVE;
            DEAD:    hp_d = 8'd0;
            default: state_d = ALIVE;
         endcase
      end

      invuln_d = (state_d == INVULN);
      death_d  = (state_d == DEAD);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ALIVE;
         x_q      <= X_RST;
         y_q      <= Y_RST;
         hp_q     <= HP_MAX;
         move_q   <= 1'b0;
         invuln_q <= 1'b0;
         death_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         hp_q     <= hp_d;
         move_q   <= move_d;
         invuln_q <= invuln_d;
         death_q  <= death_d;
      end
   end

   assign player_x = x_q;
   assign player_y = y_q;
   assign hp       = hp_q;
   assign is_move  = move_q;
   assign invuln   = invuln_q;
   assign is_death = death_q;

endmodule
